// File: rtl/irq_encoder.sv
// Purpose: captures rising edges on request lines into a pending register and presents one
//          unmasked pending request as a binary index, retired by a valid/ack handshake.
// Latency: request sampled at edge k -> pending after edge k, valid/index after edge k+1.
// Backpressure: index is held stable while valid until ack; dropping enable withdraws it.
//
// Ports: clk, rst (async active-high); enable, req[INPUTS], mask[INPUTS], ack in;
//        valid, index[OUTPUT_WIDTH], pending[INPUTS], overrun out (all registered).
// Option: define IRQ_ENCODER_ROUND_ROBIN_EN for round-robin selection (default fixed priority,
//         lowest eligible index wins).
module irq_encoder #(
    parameter int OUTPUT_WIDTH = 4,
    parameter int INPUTS       = 2**OUTPUT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [INPUTS-1:0]       req,
    input  logic [INPUTS-1:0]       mask,
    input  logic                    ack,
    output logic                    valid,
    output logic [OUTPUT_WIDTH-1:0] index,
    output logic [INPUTS-1:0]       pending,
    output logic                    overrun
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    valid_nxt;
    logic [OUTPUT_WIDTH-1:0] index_nxt;

    logic [INPUTS-1:0]       req_q;
    logic [INPUTS-1:0]       req_edge;
    logic [INPUTS-1:0]       clear;
    logic [INPUTS-1:0]       eligible;
    logic                    retire;

    logic                    sel_found;
    logic [OUTPUT_WIDTH-1:0] sel_idx;

    assign retire   = (state == PRESENT) && ack;
    assign req_edge = req & ~req_q;
    assign eligible = pending & ~mask;

    // One-hot of the presented index, only in the retiring cycle.
    always_comb begin
        clear = '0;
        for (int i = 0; i < INPUTS; i++) begin
            clear[i] = retire && (index == OUTPUT_WIDTH'(i));
        end
    end

`ifdef IRQ_ENCODER_ROUND_ROBIN_EN
    // Last retired index; search starts just above it and wraps.
    logic [OUTPUT_WIDTH-1:0] rr_ptr;
    logic                    hi_found;
    logic [OUTPUT_WIDTH-1:0] hi_idx;
    logic                    lo_found;
    logic [OUTPUT_WIDTH-1:0] lo_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= OUTPUT_WIDTH'(INPUTS-1);
        end else if (retire) begin
            rr_ptr <= index;
        end
    end

    // Lowest eligible above the pointer wins; if none, the lowest eligible overall
    // (the wrapped part of the search).
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int i = INPUTS-1; i >= 0; i--) begin
            if (eligible[i]) begin
                lo_found = 1'b1;
                lo_idx   = OUTPUT_WIDTH'(i);
                if (OUTPUT_WIDTH'(i) > rr_ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = OUTPUT_WIDTH'(i);
                end
            end
        end
        sel_found = lo_found;
        sel_idx   = hi_found ? hi_idx : lo_idx;
    end
`else
    // Fixed priority: scanning downward leaves the lowest eligible index.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = INPUTS-1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_found = 1'b1;
                sel_idx   = OUTPUT_WIDTH'(i);
            end
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        valid_nxt = valid;
        index_nxt = index;
        case (state)
            IDLE: begin
                if (enable && sel_found) begin
                    index_nxt = sel_idx;
                    valid_nxt = 1'b1;
                    state_nxt = PRESENT;
                end else begin
                    valid_nxt = 1'b0;
                end
            end
            PRESENT: begin
                // ack outranks enable=0; either way the index is released.
                if (ack || !enable) begin
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                valid_nxt = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            valid   <= 1'b0;
            index   <= '0;
            req_q   <= '0;
            pending <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            valid   <= valid_nxt;
            index   <= index_nxt;
            req_q   <= req;
            // A fresh edge on the retiring line re-sets it (set wins over clear).
            pending <= (pending & ~clear) | req_edge;
            overrun <= |(req_edge & pending & ~clear);
        end
    end

endmodule
